// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: sizes, loader states and state helpers.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH  = 64;
  localparam int unsigned IMEM_ADDR_W = 6;
  localparam int unsigned INST_W      = 16;
  localparam int unsigned BYTE_W      = 8;

  typedef enum logic [3:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DAT_HI,
    DAT_LO,
    CHK_HI,
    CHK_LO,
    DONE,
    ERR
  } loader_state_e;

  // States in which a frame is in flight: stream accepted and pipeline stalled.
  function automatic logic is_busy(input loader_state_e s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DAT_HI) || (s == DAT_LO) ||
           (s == CHK_HI) || (s == CHK_LO);
  endfunction

  // States whose transfer carries the high byte of a 16-bit field.
  function automatic logic is_hi_byte(input loader_state_e s);
    return (s == HDR_HI) || (s == DAT_HI) || (s == CHK_HI);
  endfunction

endpackage

// File: rtl/imem_loader_byte_pair_assembler.sv
// Latches a high byte, combines it with the following low byte and emits a registered
// word plus a one-cycle word-valid pulse.
module byte_pair_assembler
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = INST_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hi_load_i,
  input  logic                word_load_i,
  input  logic [DATA_W/2-1:0] byte_i,
  output logic [DATA_W-1:0]   pair_c_o,
  output logic                word_valid_o,
  output logic [DATA_W-1:0]   word_o
);

  localparam int unsigned HALF_W = DATA_W / 2;

  logic [HALF_W-1:0] hi_q;
  logic [DATA_W-1:0] word_q;
  logic              valid_q;

  // Live {hi, lo} view used for header, data and checksum decisions on the transfer edge.
  assign pair_c_o = {hi_q, byte_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= word_load_i;
      if (hi_load_i) begin
        hi_q <= byte_i;
      end
      if (word_load_i) begin
        word_q <= pair_c_o;
      end
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: parses a counted, XOR-checksummed byte frame,
// writes words from address 0 upward and holds the CPU while loading.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  loader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  words_q;
  logic [DATA_W-1:0] chk_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              ready_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic              xfer_c;
  logic              hi_load_c;
  logic              word_load_c;
  logic              hdr_bad_c;
  logic              last_word_c;
  logic              chk_ok_c;
  logic              restart_c;
  logic [DATA_W-1:0] pair_c;

  assign xfer_c      = byte_valid & ready_q;
  assign hi_load_c   = xfer_c & is_hi_byte(state_q);
  assign word_load_c = xfer_c & (state_q == DAT_LO);
  assign hdr_bad_c   = (pair_c == '0) || (pair_c > DATA_W'(DEPTH));
  assign last_word_c = (words_q + CNT_W'(1)) == cnt_q;
  assign chk_ok_c    = (pair_c == chk_q);
  assign restart_c   = start & ~is_busy(state_q);

  byte_pair_assembler #(
    .DATA_W(DATA_W)
  ) u_bpa (
    .clk         (clk),
    .rst_n       (rst_n),
    .hi_load_i   (hi_load_c),
    .word_load_i (word_load_c),
    .byte_i      (byte_in),
    .pair_c_o    (pair_c),
    .word_valid_o(imem_we),
    .word_o      (imem_wdata)
  );

  // Next-state decode; all outputs are registered below from state_d.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (start)  state_d = HDR_HI;
      HDR_HI:          if (xfer_c) state_d = HDR_LO;
      HDR_LO:          if (xfer_c) state_d = hdr_bad_c ? ERR : DAT_HI;
      DAT_HI:          if (xfer_c) state_d = DAT_LO;
      DAT_LO:          if (xfer_c) state_d = last_word_c ? CHK_HI : DAT_HI;
      CHK_HI:          if (xfer_c) state_d = CHK_LO;
      CHK_LO:          if (xfer_c) state_d = chk_ok_c ? DONE : ERR;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      words_q <= '0;
      chk_q   <= '0;
      waddr_q <= '0;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= is_busy(state_d);
      hold_q  <= is_busy(state_d) | word_load_c;

      if (restart_c) begin
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        words_q <= '0;
        chk_q   <= '0;
      end

      if (xfer_c && (state_q == HDR_LO)) begin
        cnt_q <= CNT_W'(pair_c);
        if (hdr_bad_c) begin
          err_q <= 1'b1;
        end
      end

      if (word_load_c) begin
        waddr_q <= ADDR_W'(words_q);
        chk_q   <= chk_q ^ pair_c;
        words_q <= words_q + CNT_W'(1);
      end

      if (xfer_c && (state_q == CHK_LO)) begin
        done_q <= chk_ok_c;
        err_q  <= ~chk_ok_c;
      end
    end
  end

  assign byte_ready   = ready_q;
  assign cpu_hold     = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign imem_waddr   = waddr_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued by the stimulus and
// checked by an independent monitor; frame status is checked after each frame.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [6:0]  words_loaded;

  int n_cmp = 0;
  int n_err = 0;
  logic [21:0] exp_q[$];

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .cpu_hold    (cpu_hold),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", imem_waddr, imem_wdata);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_waddr), 32'(e[21:16]));
        check("write_data", 32'(imem_wdata), 32'(e[15:0]));
        check("hold_during_we", 32'(cpu_hold), 32'd1);
      end
    end
  end

  task automatic expect_write(input logic [5:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a byte after 'gap' idle cycles and returns just after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (byte_ready) begin
        tick();
        byte_valid = 1'b0;
        return;
      end
    end
    byte_valid = 1'b0;
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: byte 0x%0h not accepted, ready %0b expected 1", b, byte_ready);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input int w);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_words"}, 32'(words_loaded), 32'(w));
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_waddr"}, 32'(imem_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, time %0t expected < 200000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;
    logic [15:0] x;
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #12;
    check_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Basic two-word load.
    pulse_start();
    check("hdr_ready", 32'(byte_ready), 32'd1);
    check("hdr_hold", 32'(cpu_hold), 32'd1);
    expect_write(6'd0, 16'h1D8A);
    expect_write(6'd1, 16'h100C);
    send_word(16'h0002, 0);
    send_word(16'h1D8A, 0);
    send_word(16'h100C, 0);
    send_byte(8'h0D, 0);
    check("chk_lo_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h86, 0);
    check_status("basic", 1'b1, 1'b0, 2);
    drain();

    // Bad checksum: writes still happen, then err.
    pulse_start();
    check("restart_done_clr", 32'(done), 32'd0);
    expect_write(6'd0, 16'h1D8A);
    expect_write(6'd1, 16'h100C);
    send_word(16'h0002, 0);
    send_word(16'h1D8A, 0);
    send_word(16'h100C, 0);
    send_word(16'h0D87, 0);
    check_status("badchk", 1'b0, 1'b1, 2);
    drain();

    // Zero count and oversize count.
    pulse_start();
    send_word(16'h0000, 0);
    check_status("cnt0", 1'b0, 1'b1, 0);
    pulse_start();
    send_word(16'h0041, 1);
    check_status("cnt65", 1'b0, 1'b1, 0);
    drain();

    // Full 64-word load with random gaps.
    pulse_start();
    send_word(16'h0040, 0);
    x = 16'h0000;
    for (int i = 0; i < 64; i++) begin
      w = {8'(i) ^ 8'h3C, 8'(i * 7 + 1)};
      x = x ^ w;
      expect_write(6'(i), w);
      send_word(w, int'($urandom_range(0, 2)));
    end
    send_word(x, 1);
    check_status("full", 1'b1, 1'b0, 64);
    check("full_last_addr", 32'(imem_waddr), 32'd63);
    check("full_last_data", 32'(imem_wdata), 32'(w));
    drain();

    // Reset mid-load after 3 of 5 words.
    pulse_start();
    send_word(16'h0005, 0);
    expect_write(6'd0, 16'h1111);
    expect_write(6'd1, 16'h2222);
    expect_write(6'd2, 16'h3333);
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    send_word(16'h3333, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_queue", 32'(exp_q.size()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    expect_write(6'd0, 16'hC00A);
    send_word(16'h0001, 0);
    send_word(16'hC00A, 0);
    send_word(16'hC00A, 0);
    check_status("after_reset", 1'b1, 1'b0, 1);
    drain();

    // Start pulse while in DAT_LO is ignored.
    pulse_start();
    expect_write(6'd0, 16'h1234);
    expect_write(6'd1, 16'h5678);
    send_word(16'h0002, 0);
    send_word(16'h1234, 0);
    send_byte(8'h56, 0);
    pulse_start();
    check("busy_start_ready", 32'(byte_ready), 32'd1);
    check("busy_start_words", 32'(words_loaded), 32'd1);
    send_byte(8'h78, 0);
    send_word(16'h444C, 0);
    check_status("busy_start", 1'b1, 1'b0, 2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
